// File: rtl/ewrapper_tx_serdes_par.sv
// Parallel-to-DDR e-link transmit serializer: small input FIFO feeding NCH
// channels, MSB-first, one even/odd pair per clock. Option macro: ELINK_TX_INVERT_EN.
module ewrapper_tx_serdes_par #(
    parameter int NCH   = 9,
    parameter int BPC   = 8,
    parameter int DEPTH = 2
) (
    input  logic               CLK_IN,
    input  logic               RESET_N,
    input  logic               ENABLE,
    input  logic [NCH*BPC-1:0] DATA_IN,
    input  logic               DATA_VALID,
    output logic               DATA_READY,
    output logic [NCH-1:0]     EVEN_OUT,
    output logic [NCH-1:0]     ODD_OUT,
    output logic               BUSY,
    output logic               UNDERRUN
);

    localparam int W  = NCH * BPC;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (BPC > 2) ? $clog2(BPC / 2) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(BPC / 2 - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic [W-1:0]    word_q, word_d;
    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ready_q, ready_d;
    logic [NCH-1:0]  even_q, even_d;
    logic [NCH-1:0]  odd_q, odd_d;
    logic            busy_q;
    logic            underrun_q, underrun_d;
    logic            push_s, pop_s, empty_s;
    logic [W-1:0]    rd_data_s;
    logic [NCH-1:0]  top_even_s, top_odd_s;
    logic [NCH-1:0]  even_raw_s, odd_raw_s;

    assign push_s    = DATA_VALID && ready_q;
    assign empty_s   = (count_q == {CW{1'b0}});
    assign rd_data_s = mem_q[rd_ptr_q];

    // The word shifts left two bits per cycle, so each channel's next pair is
    // always in its top two bits; bits leaking in from the channel below never
    // reach the top before the next reload.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign top_even_s[c] = word_q[c*BPC + BPC - 1];
        assign top_odd_s[c]  = word_q[c*BPC + BPC - 2];
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CW'(DEPTH));
    end

    // Serializer FSM next-state, pop request and underrun detection
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        word_d     = word_q;
        pop_s      = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ENABLE && !empty_s) begin
                    pop_s   = 1'b1;
                    word_d  = rd_data_s;
                    ph_d    = {PW{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (ph_q == PH_LAST) begin
                    ph_d = {PW{1'b0}};
                    if (ENABLE && !empty_s) begin
                        pop_s   = 1'b1;
                        word_d  = rd_data_s;
                        state_d = ST_SHIFT;
                    end else if (ENABLE) begin
                        underrun_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    ph_d   = ph_q + PW'(1'b1);
                    word_d = word_q << 2'd2;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ph_d    = {PW{1'b0}};
            end
        endcase
    end

    // Output pair selection with optional line inversion
    always_comb begin
        if (state_q == ST_SHIFT) begin
            even_raw_s = top_even_s;
            odd_raw_s  = top_odd_s;
        end else begin
            even_raw_s = {NCH{1'b0}};
            odd_raw_s  = {NCH{1'b0}};
        end
`ifdef ELINK_TX_INVERT_EN
        even_d = ~even_raw_s;
        odd_d  = ~odd_raw_s;
`else
        even_d = even_raw_s;
        odd_d  = odd_raw_s;
`endif
    end

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge CLK_IN) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= DATA_IN;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            ph_q       <= {PW{1'b0}};
            word_q     <= {W{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            ready_q    <= 1'b0;
            even_q     <= {NCH{1'b0}};
            odd_q      <= {NCH{1'b0}};
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            word_q     <= word_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            even_q     <= even_d;
            odd_q      <= odd_d;
            busy_q     <= (state_d == ST_SHIFT);
            underrun_q <= underrun_d;
        end
    end

    assign DATA_READY = ready_q;
    assign EVEN_OUT   = even_q;
    assign ODD_OUT    = odd_q;
    assign BUSY       = busy_q;
    assign UNDERRUN   = underrun_q;

endmodule

// File: tb/tb_ewrapper_tx_serdes_par.sv
// Scoreboard bench for ewrapper_tx_serdes_par: expected pairs are queued at
// push time and popped one per output cycle by a negedge monitor.
module tb_ewrapper_tx_serdes_par;

    localparam int NCH   = 9;
    localparam int BPC   = 8;
    localparam int DEPTH = 2;
    localparam int W     = NCH * BPC;
`ifdef ELINK_TX_INVERT_EN
    localparam logic [NCH-1:0] IDLE_V = {NCH{1'b1}};
`else
    localparam logic [NCH-1:0] IDLE_V = {NCH{1'b0}};
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic [W-1:0]   data_in;
    logic           data_valid;
    logic           data_ready;
    logic [NCH-1:0] even_out;
    logic [NCH-1:0] odd_out;
    logic           busy;
    logic           underrun;

    always #5 clk = ~clk;

    ewrapper_tx_serdes_par #(.NCH(NCH), .BPC(BPC), .DEPTH(DEPTH)) dut (
        .CLK_IN     (clk),
        .RESET_N    (rst_n),
        .ENABLE     (enable),
        .DATA_IN    (data_in),
        .DATA_VALID (data_valid),
        .DATA_READY (data_ready),
        .EVEN_OUT   (even_out),
        .ODD_OUT    (odd_out),
        .BUSY       (busy),
        .UNDERRUN   (underrun)
    );

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [2*NCH-1:0] exp_q[$];
    int               under_cnt = 0;
    int               busy_run  = 0;
    int               last_run  = 0;
    logic             busy_prev = 1'b0;
    logic             armed     = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input logic [W-1:0] w);
        logic [NCH-1:0] e, o;
        for (int p = 0; p < BPC / 2; p++) begin
            for (int c = 0; c < NCH; c++) begin
                e[c] = w[c*BPC + BPC - 1 - 2*p];
                o[c] = w[c*BPC + BPC - 2 - 2*p];
            end
            exp_q.push_back({e ^ IDLE_V, o ^ IDLE_V});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        int n = 0;
        while (!data_ready && n < 100) begin
            tick();
            n++;
        end
        check_eq("push_ready", 32'(data_ready), 32'd1);
        data_in    = w;
        data_valid = 1'b1;
        push_expect(w);
        tick();
        data_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        tick();
        tick();
        check_eq("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 20) begin
            tick();
            n++;
        end
        check_eq("wait_busy", 32'(busy), 32'd1);
    endtask

    // Output monitor: one expected pair per cycle following a SHIFT cycle, else idle
    always @(negedge clk) begin
        if (!rst_n) begin
            armed     = 1'b0;
            busy_prev = 1'b0;
            busy_run  = 0;
        end else if (!armed) begin
            armed     = 1'b1;
            busy_prev = busy;
        end else begin
            if (busy_prev) begin
                check_eq("pair_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [2*NCH-1:0] e;
                    e = exp_q.pop_front();
                    check_eq("even_pair", 32'(even_out), 32'(e[2*NCH-1:NCH]));
                    check_eq("odd_pair",  32'(odd_out),  32'(e[NCH-1:0]));
                end
            end else begin
                check_eq("even_idle", 32'(even_out), 32'(IDLE_V));
                check_eq("odd_idle",  32'(odd_out),  32'(IDLE_V));
            end
            if (underrun) under_cnt++;
            if (busy) begin
                busy_run++;
            end else if (busy_run > 0) begin
                last_run = busy_run;
                busy_run = 0;
            end
            busy_prev = busy;
        end
    end

    initial begin
        int u0;
        int b;
        rst_n      = 1'b0;
        enable     = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        #3;
        check_eq("rst_ready",    32'(data_ready), 32'd0);
        check_eq("rst_even",     32'(even_out),   32'd0);
        check_eq("rst_odd",      32'(odd_out),    32'd0);
        check_eq("rst_busy",     32'(busy),       32'd0);
        check_eq("rst_underrun", 32'(underrun),   32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("ready_before_edge", 32'(data_ready), 32'd0);
        tick();
        check_eq("ready_after_edge", 32'(data_ready), 32'd1);

        // Single word from IDLE: exact timing and named channel values
        enable = 1'b1;
        u0 = under_cnt;
        push_word(72'h80_40_20_10_08_04_02_01_FF);
        for (int s = 0; s < 7; s++) begin
            @(negedge clk);
            check_eq("t1_busy",     32'(busy),     32'((s >= 1) && (s <= 4)));
            check_eq("t1_underrun", 32'(underrun), 32'(s == 5));
            if (s >= 2 && s <= 5) begin
                check_eq("t1_ch0_even", 32'(even_out[0]), 32'(1'b1 ^ IDLE_V[0]));
                check_eq("t1_ch0_odd",  32'(odd_out[0]),  32'(1'b1 ^ IDLE_V[0]));
                check_eq("t1_ch8_even", 32'(even_out[8]), 32'((s == 2) ^ IDLE_V[8]));
                check_eq("t1_ch8_odd",  32'(odd_out[8]),  32'(1'b0 ^ IDLE_V[8]));
            end
        end
        drain();
        check_eq("t1_underrun_cnt", 32'(under_cnt - u0), 32'd1);

        // Three words back to back: gap-free stream, one underrun
        u0 = under_cnt;
        push_word(72'hA5_5A_C3_3C_96_69_F0_0F_11);
        push_word(72'h01_23_45_67_89_AB_CD_EF_55);
        push_word(72'hFE_DC_BA_98_76_54_32_10_AA);
        drain();
        check_eq("t2_run_len",      32'(last_run),        32'd12);
        check_eq("t2_underrun_cnt", 32'(under_cnt - u0),  32'd1);

        // Fill FIFO with ENABLE low; third word must be ignored
        enable = 1'b0;
        u0 = under_cnt;
        data_valid = 1'b1;
        data_in = 72'h11_22_33_44_55_66_77_88_99;
        push_expect(data_in);
        tick();
        check_eq("t3_ready_1", 32'(data_ready), 32'd1);
        data_in = 72'h9A_BC_DE_F0_12_34_56_78_0F;
        push_expect(data_in);
        tick();
        check_eq("t3_ready_full", 32'(data_ready), 32'd0);
        data_in = 72'hDE_AD_BE_EF_CA_FE_BA_BE_77;
        tick();
        tick();
        data_valid = 1'b0;
        check_eq("t3_busy_held", 32'(busy), 32'd0);
        enable = 1'b1;
        drain();
        check_eq("t3_underrun_cnt", 32'(under_cnt - u0), 32'd1);

        // ENABLE dropped at PH=1: word completes, no underrun, next word kept
        enable = 1'b0;
        u0 = under_cnt;
        push_word(72'h3C_C3_5A_A5_0F_F0_69_96_81);
        push_word(72'hC0_FF_EE_12_34_56_78_9A_BC);
        enable = 1'b1;
        wait_busy();
        tick();
        enable = 1'b0;
        b = 0;
        while (busy && b < 20) begin
            tick();
            b++;
        end
        repeat (3) tick();
        check_eq("t4_no_underrun", 32'(under_cnt - u0),  32'd0);
        check_eq("t4_retained",    32'(exp_q.size()),    32'(BPC / 2));
        check_eq("t4_ready",       32'(data_ready),      32'd1);
        enable = 1'b1;
        drain();
        check_eq("t4_underrun_cnt", 32'(under_cnt - u0), 32'd1);

        // Reset at PH=2 with one word queued: everything discarded
        enable = 1'b0;
        push_word(72'h77_66_55_44_33_22_11_00_FF);
        push_word(72'h0F_1E_2D_3C_4B_5A_69_78_87);
        enable = 1'b1;
        wait_busy();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("t5_even",     32'(even_out),   32'd0);
        check_eq("t5_odd",      32'(odd_out),    32'd0);
        check_eq("t5_busy",     32'(busy),       32'd0);
        check_eq("t5_ready",    32'(data_ready), 32'd0);
        check_eq("t5_underrun", 32'(underrun),   32'd0);
        exp_q.delete();
        u0 = under_cnt;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("t5_ready_after", 32'(data_ready), 32'd1);
        b = 0;
        repeat (12) begin
            tick();
            if (busy) b++;
        end
        check_eq("t5_no_stale",    32'(b),               32'd0);
        check_eq("t5_no_underrun", 32'(under_cnt - u0),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
